// File: rtl/player_laser.sv
`timescale 1ns/1ps
// player_laser
// Single-shot player laser. It edge-detects the shoot button and latches the
// gun column, clamped so the laser never runs past the right screen edge.
// The laser launches on the next frame pulse and climbs speed_p rows per
// frame until it is hit or expires at top_limit_p. A frame-counted cooldown
// then gates the next shot. laser_area_o is a zero-latency pixel mask.
//
// Ports
//   clk_i          pixel clock
//   reset_n_i      asynchronous active-low reset
//   frame_i        one-cycle pulse per frame (vertical blanking)
//   fire_i         synchronised shoot button, level
//   gun_pos_i      gun column from the player block
//   hit_i          laser struck a target, one-cycle pulse
//   x_i, y_i       current pixel column / row
//   ready_o        a shot can be accepted
//   active_o       laser is in flight
//   fired_o        one-cycle pulse at launch
//   laser_x_o      left column of the laser
//   laser_y_o      top row of the laser
//   laser_area_o   current pixel lies inside the laser
module player_laser #(
  parameter int unsigned laser_w_p   = 2,
  parameter int unsigned laser_h_p   = 8,
  parameter int unsigned spawn_y_p   = 392,
  parameter int unsigned speed_p     = 4,
  parameter int unsigned top_limit_p = 32,
  parameter int unsigned cooldown_p  = 8
) (
  input  logic       clk_i,
  input  logic       reset_n_i,
  input  logic       frame_i,
  input  logic       fire_i,
  input  logic [9:0] gun_pos_i,
  input  logic       hit_i,
  input  logic [9:0] x_i,
  input  logic [9:0] y_i,
  output logic       ready_o,
  output logic       active_o,
  output logic       fired_o,
  output logic [9:0] laser_x_o,
  output logic [9:0] laser_y_o,
  output logic       laser_area_o
);

  typedef enum logic [1:0] {IDLE, ARMED, FLYING, COOLDOWN} state_e;

  localparam logic [9:0]  MaxX    = 10'(640 - laser_w_p);
  localparam logic [9:0]  SpawnY  = 10'(spawn_y_p);
  localparam logic [9:0]  Speed   = 10'(speed_p);
  localparam logic [10:0] ExpireY = 11'(top_limit_p + speed_p);
  localparam logic [3:0]  CoolCnt = 4'(cooldown_p);
  localparam logic [10:0] LaserW  = 11'(laser_w_p);
  localparam logic [10:0] LaserH  = 11'(laser_h_p);

  state_e     state_q, state_d;
  logic       fire_q;
  logic [9:0] laser_x_q, laser_x_d;
  logic [9:0] laser_y_q, laser_y_d;
  logic [3:0] cnt_q, cnt_d;
  logic       fire_edge;

  assign fire_edge = fire_i & ~fire_q;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= IDLE;
      fire_q    <= 1'b0;
      laser_x_q <= '0;
      laser_y_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      fire_q    <= fire_i;
      laser_x_q <= laser_x_d;
      laser_y_q <= laser_y_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    laser_x_d = laser_x_q;
    laser_y_d = laser_y_q;
    cnt_d     = cnt_q;
    fired_o   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (fire_edge) begin
          state_d   = ARMED;
          laser_x_d = (gun_pos_i > MaxX) ? MaxX : gun_pos_i;
        end
      end
      ARMED: begin
        if (frame_i) begin
          state_d   = FLYING;
          laser_y_d = SpawnY;
          fired_o   = 1'b1;
        end
      end
      FLYING: begin
        // Hit has priority over the frame move; the expiry test keeps
        // laser_y from ever being subtracted below top_limit_p.
        if (hit_i) begin
          state_d = COOLDOWN;
          cnt_d   = CoolCnt;
        end else if (frame_i) begin
          if ({1'b0, laser_y_q} < ExpireY) begin
            state_d = COOLDOWN;
            cnt_d   = CoolCnt;
          end else begin
            laser_y_d = laser_y_q - Speed;
          end
        end
      end
      COOLDOWN: begin
        if (CoolCnt == 4'd0) begin
          state_d = IDLE;
        end else if (frame_i) begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ready_o   = (state_q == IDLE);
  assign active_o  = (state_q == FLYING);
  assign laser_x_o = laser_x_q;
  assign laser_y_o = laser_y_q;

  // 11-bit comparisons so laser_x + width / laser_y + height cannot wrap.
  assign laser_area_o = (state_q == FLYING)
                     && ({1'b0, x_i} >= {1'b0, laser_x_q})
                     && ({1'b0, x_i} <  ({1'b0, laser_x_q} + LaserW))
                     && ({1'b0, y_i} >= {1'b0, laser_y_q})
                     && ({1'b0, y_i} <  ({1'b0, laser_y_q} + LaserH));

endmodule
